// File: rtl/msl_pkg.sv
// Shared MSL line encoding: FSM states and segment lengths in ticks.
// Used by both the master transmitter and the receiver side.
package msl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_SYNC  = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4,
        ST_GAP   = 3'd5
    } msl_state_e;

    // Segment tick counter width; the longest segment (GAP) must fit.
    localparam int unsigned SEG_CNT_W = 5;

    localparam int unsigned T_START = 10;
    localparam int unsigned T_SYNC  = 2;
    localparam int unsigned T_ONE   = 10;
    localparam int unsigned T_ZERO  = 4;
    localparam int unsigned T_STOP  = 10;
    localparam int unsigned T_GAP   = 25;

    // Length in ticks of the segment driven in a given state.
    function automatic logic [SEG_CNT_W-1:0] seg_ticks(input msl_state_e st, input logic bit_val);
        logic [SEG_CNT_W-1:0] len;
        case (st)
            ST_START: len = SEG_CNT_W'(T_START);
            ST_SYNC:  len = SEG_CNT_W'(T_SYNC);
            ST_DATA:  len = bit_val ? SEG_CNT_W'(T_ONE) : SEG_CNT_W'(T_ZERO);
            ST_STOP:  len = SEG_CNT_W'(T_STOP);
            ST_GAP:   len = SEG_CNT_W'(T_GAP);
            default:  len = SEG_CNT_W'(1);
        endcase
        return len;
    endfunction

endpackage

// File: rtl/msl_tick_gen.sv
// Segment time base: one-clock tick every P_DIV+1 clocks, restartable by i_clr.
module msl_tick_gen #(
    parameter int unsigned P_DIV = 49_999
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    output logic o_tick
);
    localparam int unsigned CNT_W = $clog2(P_DIV + 2);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt_c;

    // Next count value, wrapping at the terminal count.
    always_comb begin
        cnt_nxt_c = (cnt_q == CNT_W'(P_DIV)) ? '0 : cnt_q + CNT_W'(1);
    end

    // Counter plus registered tick, raised in the cycle the count sits at terminal.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            cnt_q  <= '0;
            o_tick <= (P_DIV == 0);
        end else begin
            cnt_q  <= cnt_nxt_c;
            o_tick <= (cnt_nxt_c == CNT_W'(P_DIV));
        end
    end

endmodule

// File: rtl/msl_master_transmitter.sv
// MSL master transmitter: START / SYNC / DATA / STOP / GAP frame on o_msl_sda.
// Optional build macro MSL_TX_PARITY_EN appends an even-parity DATA segment.
module msl_master_transmitter
    import msl_pkg::*;
#(
    parameter int unsigned P_DATA_WIDTH = 8,
    parameter int unsigned P_SYSTEM_CLK = 50_000_000,
    parameter int unsigned P_TICK_HZ    = 1000
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [P_DATA_WIDTH-1:0] i_data,
    input  logic                    i_valid,
    output logic                    o_ready,
    output logic                    o_msl_sda,
    output logic                    o_busy,
    output logic                    o_done
);
    localparam int unsigned DIV = P_SYSTEM_CLK / P_TICK_HZ - 1;
`ifdef MSL_TX_PARITY_EN
    localparam int unsigned FRAME_BITS = P_DATA_WIDTH + 1;
`else
    localparam int unsigned FRAME_BITS = P_DATA_WIDTH;
`endif
    localparam int unsigned IDX_W = $clog2(P_DATA_WIDTH + 1);

    msl_state_e             state_q;
    logic [FRAME_BITS-1:0]  shift_q;
    logic [IDX_W-1:0]       bit_idx_q;
    logic [SEG_CNT_W-1:0]   seg_cnt_q;
    logic                   tick;
    logic                   accept_c;
    logic                   seg_end_c;

    assign accept_c = i_valid && o_ready;

    // Divider restarts on accept so every segment boundary is tick-aligned to it.
    msl_tick_gen #(
        .P_DIV (DIV)
    ) u_tick_gen (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (accept_c),
        .o_tick (tick)
    );

    // Current segment finishes on this tick.
    always_comb begin
        seg_end_c = tick && (seg_cnt_q == seg_ticks(state_q, shift_q[FRAME_BITS-1]) - SEG_CNT_W'(1));
    end

    // Frame sequencer; the line level always changes at a segment boundary except into GAP.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            seg_cnt_q <= '0;
            o_msl_sda <= 1'b1;
            o_ready   <= 1'b1;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (state_q == ST_IDLE) begin
                if (i_valid) begin
`ifdef MSL_TX_PARITY_EN
                    shift_q <= {i_data, ^i_data};
`else
                    shift_q <= i_data;
`endif
                    state_q   <= ST_START;
                    bit_idx_q <= '0;
                    seg_cnt_q <= '0;
                    o_msl_sda <= 1'b0;
                    o_ready   <= 1'b0;
                    o_busy    <= 1'b1;
                end
            end else if (tick) begin
                if (!seg_end_c) begin
                    seg_cnt_q <= seg_cnt_q + SEG_CNT_W'(1);
                end else begin
                    seg_cnt_q <= '0;
                    case (state_q)
                        ST_START: begin
                            state_q   <= ST_SYNC;
                            o_msl_sda <= 1'b1;
                        end
                        ST_SYNC: begin
                            state_q   <= ST_DATA;
                            o_msl_sda <= 1'b0;
                        end
                        ST_DATA: begin
                            o_msl_sda <= ~o_msl_sda;
                            if (bit_idx_q == IDX_W'(FRAME_BITS - 1)) begin
                                state_q <= ST_STOP;
                            end else begin
                                bit_idx_q <= bit_idx_q + IDX_W'(1);
                                shift_q   <= shift_q << 1;
                            end
                        end
                        ST_STOP: begin
                            state_q   <= ST_GAP;
                            o_msl_sda <= 1'b1;
                        end
                        ST_GAP: begin
                            state_q <= ST_IDLE;
                            o_ready <= 1'b1;
                            o_busy  <= 1'b0;
                            o_done  <= 1'b1;
                        end
                        default: begin
                            state_q <= ST_IDLE;
                            o_ready <= 1'b1;
                            o_busy  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/msl_master_transmitter.md
MSL_MASTER_TRANSMITTER -- requirements
Module: msl_master_transmitter

Interface
REQ-001 SHALL have parameter P_DATA_WIDTH, default 8, payload bits per frame.
REQ-002 SHALL have parameter P_SYSTEM_CLK, default 50_000_000, i_clk frequency in Hz.
REQ-003 SHALL have parameter P_TICK_HZ, default 1000, segment time base in Hz (1 ms).
REQ-004 SHALL have port i_clk, input, 1, single clock; all logic on rising edge.
REQ-005 SHALL have port i_rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port i_data, input, P_DATA_WIDTH, payload, MSB sent first.
REQ-007 SHALL have port i_valid, input, 1, payload offered.
REQ-008 SHALL have port o_ready, output, 1, transmitter idle and able to accept.
REQ-009 SHALL have port o_msl_sda, output, 1, serial line to the MSL slave; idle high.
REQ-010 SHALL have port o_busy, output, 1, frame in progress (equals ~o_ready).
REQ-011 SHALL have port o_done, output, 1, one-clock pulse at the end of the frame's GAP.

Function
REQ-012 SHALL derive a tick every P_SYSTEM_CLK/P_TICK_HZ clocks (terminal count DIV = P_SYSTEM_CLK/P_TICK_HZ-1); the divider is cleared on accept so segment boundaries are tick-aligned to the accept.
REQ-013 SHALL accept when i_valid && o_ready on a clock edge; latch i_data; deassert o_ready on the next cycle; drive o_msl_sda low on the next cycle.
REQ-014 SHALL ignore i_valid while o_ready is low; latched data is unaffected by i_data changes mid-frame.
REQ-015 SHALL sequence states IDLE -> START -> SYNC -> DATA -> STOP -> GAP -> IDLE; every transition occurs only on a tick.
REQ-016 START SHALL drive low for 10 ticks; SYNC SHALL drive high for 2 ticks.
REQ-017 DATA SHALL emit one level segment per bit, MSB first; bit k (k=0 is MSB) drives low for even k and high for odd k; segment length is 10 ticks for '1' and 4 ticks for '0'.
REQ-018 STOP SHALL drive the inverse of the last DATA level for 10 ticks, guaranteeing a terminating edge.
REQ-019 GAP SHALL drive high for 25 ticks; on its final tick o_done pulses for one clock and o_ready rises in the same cycle.
REQ-020 SHALL use a segment counter of at least 5 bits and a bit index of clog2(P_DATA_WIDTH+1) bits; neither wraps within a legal frame.
REQ-021 A new accept in the o_done cycle SHALL be legal; the next START begins on the following cycle with no extra idle-high time beyond GAP.

Reset
REQ-022 On i_rst: state IDLE, o_msl_sda=1, o_ready=1, o_busy=0, o_done=0, divider, counters and data register cleared.
REQ-023 Reset mid-frame SHALL abandon the frame: line high next cycle, no o_done pulse, no accept in the reset cycle.

Configuration
REQ-024 With MSL_TX_PARITY_EN defined, one even-parity bit SHALL follow the payload LSB as an extra DATA segment (same level-alternation and length rules); STOP inverts its level.
REQ-025 Without MSL_TX_PARITY_EN, DATA SHALL contain exactly P_DATA_WIDTH segments and no parity logic shall be synthesised.

Structure
REQ-026 Package msl_pkg SHALL hold the state encoding and tick-length constants (START 10, SYNC 2, ONE 10, ZERO 4, STOP 10, GAP 25), shared with the receiver side.
REQ-027 The divider SHALL be a sub-module msl_tick_gen (sync clear input, one-clock tick output).

Verification (P_SYSTEM_CLK=10_000, P_TICK_HZ=1000 -> 10 clocks/tick)
REQ-028 Reset, no valid -> o_msl_sda=1, o_ready=1, o_done never pulses for 1000 clocks.
REQ-029 Send 0xA5, parity off -> line: low 10, high 2, then segments L10 H4 L10 H4 L4 H10 L4 H10, stop L10, gap H25 ticks; o_done at 103 ticks (1030 clocks) after accept.
REQ-030 Send 0xFF then assert i_valid with 0x00 in the o_done cycle -> second frame START begins next cycle; 0x00 frame gets 8 segments of 4 ticks.
REQ-031 i_valid with new data pulsed mid-frame -> ignored; transmitted bits match the first payload.
REQ-032 Assert i_rst during DATA bit 3 -> o_msl_sda=1 next cycle, o_ready=1, no o_done; a subsequent 0x3C frame is correct.
REQ-033 MSL_TX_PARITY_EN defined, send 0x01 -> ninth segment low with length 10 (parity '1'), STOP high 10 ticks.
